morra_match_sequencer: RTL and testbench

- Controller that sequences one match on the Morra Cinese game core.
- Sets match length via the core's start cycle, collects one move per player per round through valid/ready handshakes, and issues rounds to the core.
- Watches the core's match result, then reports match end and the winner.
- Sits between the two player input front-ends and the game core; it is the core's only driver.

---
 rtl/morra_match_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_morra_match_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/morra_match_sequencer.sv
`timescale 1ns/1ps
// Match sequencer for the Morra Cinese game core: configures the core, collects one move per
// player per round, issues rounds and reports the winner. Optional forfeit timeout: MORRA_TIMEOUT_EN.
module morra_match_sequencer #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             AVVIA,
   input  logic [3:0]       CONFIG,
   input  logic [1:0]       P1_MOSSA,
   input  logic             P1_VALID,
   output logic             P1_READY,
   input  logic [1:0]       P2_MOSSA,
   input  logic             P2_VALID,
   output logic             P2_READY,
   output logic [1:0]       CORE_PRIMO,
   output logic [1:0]       CORE_SECONDO,
   output logic             CORE_INIZIA,
   input  logic [1:0]       CORE_MANCHE,
   input  logic [1:0]       CORE_PARTITA,
   output logic             OCCUPATO,
   output logic             FINE,
   output logic [1:0]       ESITO,
   output logic             FORFAIT,
   output logic [CNT_W-1:0] N_MANCHE,
   output logic [2:0]       dbg_state,
   output logic [1:0]       dbg_manche
);

   // Handshake: a move transfers on a rising edge where Px_VALID and Px_READY are both high;
   // READY is registered and only ever high in RACCOLTA while that player's holding register is empty.

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      INIT         = 3'd1,
      RACCOLTA     = 3'd2,
      EMISSIONE    = 3'd3,
      VERIFICA     = 3'd4,
      FINE_PARTITA = 3'd5
   } state_t;

   state_t     state;
   logic [1:0] p1_reg, p2_reg;
   logic       p1_full, p2_full;
   logic       p1_take, p2_take;
   logic       p1_full_n, p2_full_n;
   logic [1:0] p1_val, p2_val;

`ifdef MORRA_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] to_cnt;
   logic       forfait_q;
   assign FORFAIT = forfait_q;
`else
   assign FORFAIT = 1'b0;
`endif

   assign CORE_INIZIA = RST | (state == INIT);
   assign OCCUPATO    = (state != IDLE);
   assign dbg_state   = state;

   // A handshake carrying 00 is consumed but never fills the holding register.
   always_comb begin
      p1_take   = P1_VALID & P1_READY & (state == RACCOLTA);
      p2_take   = P2_VALID & P2_READY & (state == RACCOLTA);
      p1_full_n = p1_full | (p1_take & (P1_MOSSA != 2'b00));
      p2_full_n = p2_full | (p2_take & (P2_MOSSA != 2'b00));
      p1_val    = p1_full ? p1_reg : P1_MOSSA;
      p2_val    = p2_full ? p2_reg : P2_MOSSA;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state        <= IDLE;
         P1_READY     <= 1'b0;
         P2_READY     <= 1'b0;
         CORE_PRIMO   <= 2'b00;
         CORE_SECONDO <= 2'b00;
         FINE         <= 1'b0;
         ESITO        <= 2'b00;
         N_MANCHE     <= '0;
         p1_reg       <= 2'b00;
         p2_reg       <= 2'b00;
         p1_full      <= 1'b0;
         p2_full      <= 1'b0;
         dbg_manche   <= 2'b00;
`ifdef MORRA_TIMEOUT_EN
         to_cnt       <= 8'd0;
         forfait_q    <= 1'b0;
`endif
      end else begin
         FINE         <= 1'b0;
         CORE_PRIMO   <= 2'b00;
         CORE_SECONDO <= 2'b00;
         case (state)
            IDLE: begin
               if (AVVIA) begin
                  state                     <= INIT;
                  {CORE_PRIMO, CORE_SECONDO} <= CONFIG;
               end
            end
            INIT: begin
               ESITO    <= 2'b00;
               N_MANCHE <= '0;
               p1_reg   <= 2'b00;
               p2_reg   <= 2'b00;
               p1_full  <= 1'b0;
               p2_full  <= 1'b0;
               P1_READY <= 1'b1;
               P2_READY <= 1'b1;
               state    <= RACCOLTA;
`ifdef MORRA_TIMEOUT_EN
               to_cnt    <= 8'd0;
               forfait_q <= 1'b0;
`endif
            end
            RACCOLTA: begin
               if (p1_take && (P1_MOSSA != 2'b00)) begin
                  p1_reg  <= P1_MOSSA;
                  p1_full <= 1'b1;
               end
               if (p2_take && (P2_MOSSA != 2'b00)) begin
                  p2_reg  <= P2_MOSSA;
                  p2_full <= 1'b1;
               end
               if (p1_full_n && p2_full_n) begin
                  // Present the round to the core already during EMISSIONE.
                  state        <= EMISSIONE;
                  CORE_PRIMO   <= p1_val;
                  CORE_SECONDO <= p2_val;
                  P1_READY     <= 1'b0;
                  P2_READY     <= 1'b0;
`ifdef MORRA_TIMEOUT_EN
                  to_cnt       <= 8'd0;
`endif
               end else begin
                  P1_READY <= ~p1_full_n;
                  P2_READY <= ~p2_full_n;
`ifdef MORRA_TIMEOUT_EN
                  if (p1_full ^ p2_full) begin
                     if (to_cnt == TO_LAST) begin
                        state     <= FINE_PARTITA;
                        FINE      <= 1'b1;
                        ESITO     <= p1_full ? 2'b01 : 2'b10;
                        forfait_q <= 1'b1;
                        P1_READY  <= 1'b0;
                        P2_READY  <= 1'b0;
                     end else begin
                        to_cnt <= to_cnt + 8'd1;
                     end
                  end else begin
                     to_cnt <= 8'd0;
                  end
`endif
               end
            end
            EMISSIONE: begin
               if (N_MANCHE != {CNT_W{1'b1}})
                  N_MANCHE <= N_MANCHE + CNT_W'(1);
               p1_reg  <= 2'b00;
               p2_reg  <= 2'b00;
               p1_full <= 1'b0;
               p2_full <= 1'b0;
               state   <= VERIFICA;
            end
            VERIFICA: begin
               // The core registered the issued round on the previous edge.
               dbg_manche <= CORE_MANCHE;
               if (CORE_PARTITA != 2'b00) begin
                  ESITO <= CORE_PARTITA;
                  FINE  <= 1'b1;
                  state <= FINE_PARTITA;
               end else begin
                  P1_READY <= 1'b1;
                  P2_READY <= 1'b1;
                  state    <= RACCOLTA;
               end
            end
            FINE_PARTITA: state <= IDLE;
            default:      state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morra_match_sequencer.sv
`timescale 1ns/1ps
// Directed bench for morra_match_sequencer with a small behavioural game core and an
// issued-round scoreboard.
module tb_morra_match_sequencer;

   localparam int CNT_W = 5;

   logic             clk;
   logic             RST;
   logic             AVVIA;
   logic [3:0]       CONFIG;
   logic [1:0]       P1_MOSSA, P2_MOSSA;
   logic             P1_VALID, P2_VALID;
   logic             P1_READY, P2_READY;
   logic [1:0]       CORE_PRIMO, CORE_SECONDO;
   logic             CORE_INIZIA;
   logic [1:0]       core_manche, core_partita;
   logic             OCCUPATO, FINE, FORFAIT;
   logic [1:0]       ESITO;
   logic [CNT_W-1:0] N_MANCHE;
   logic [2:0]       dbg_state;
   logic [1:0]       dbg_manche;

   int n_checks = 0;
   int n_errors = 0;
   int emis_cnt = 0;
   int fine_cnt = 0;
   logic [3:0] exp_q[$];

   morra_match_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(CNT_W)) dut (
      .clk(clk), .RST(RST), .AVVIA(AVVIA), .CONFIG(CONFIG),
      .P1_MOSSA(P1_MOSSA), .P1_VALID(P1_VALID), .P1_READY(P1_READY),
      .P2_MOSSA(P2_MOSSA), .P2_VALID(P2_VALID), .P2_READY(P2_READY),
      .CORE_PRIMO(CORE_PRIMO), .CORE_SECONDO(CORE_SECONDO), .CORE_INIZIA(CORE_INIZIA),
      .CORE_MANCHE(core_manche), .CORE_PARTITA(core_partita),
      .OCCUPATO(OCCUPATO), .FINE(FINE), .ESITO(ESITO), .FORFAIT(FORFAIT),
      .N_MANCHE(N_MANCHE), .dbg_state(dbg_state), .dbg_manche(dbg_manche)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- check ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- game core model ----------------
   // 01 sasso beats 11 forbice, 11 forbice beats 10 carta, 10 carta beats 01 sasso.
   function automatic logic [1:0] round_winner(input logic [1:0] a, input logic [1:0] b);
      if (a == b) return 2'b11;
      if ((a == 2'b01 && b == 2'b11) || (a == 2'b11 && b == 2'b10) || (a == 2'b10 && b == 2'b01))
         return 2'b01;
      return 2'b10;
   endfunction

   logic [4:0] m_cnt, m_max, p1w, p2w, np1, np2;
   logic [1:0] w;

   always @(posedge clk) begin
      if (CORE_INIZIA) begin
         m_cnt        <= 5'd0;
         m_max        <= 5'({CORE_PRIMO, CORE_SECONDO}) + 5'd4;
         p1w          <= 5'd0;
         p2w          <= 5'd0;
         core_manche  <= 2'b00;
         core_partita <= 2'b00;
      end else if (CORE_PRIMO != 2'b00 && CORE_SECONDO != 2'b00 && core_partita == 2'b00) begin
         w   = round_winner(CORE_PRIMO, CORE_SECONDO);
         np1 = p1w + ((w == 2'b01) ? 5'd1 : 5'd0);
         np2 = p2w + ((w == 2'b10) ? 5'd1 : 5'd0);
         core_manche <= w;
         p1w         <= np1;
         p2w         <= np2;
         m_cnt       <= m_cnt + 5'd1;
         if (m_cnt + 5'd1 == m_max)
            core_partita <= (np1 > np2) ? 2'b01 : (np2 > np1) ? 2'b10 : 2'b11;
      end else begin
         core_manche <= 2'b00;
      end
   end

   // ---------------- scoreboard / monitors ----------------
   always @(negedge clk) begin
      if (FINE) fine_cnt++;
      if (!CORE_INIZIA && (CORE_PRIMO != 2'b00 || CORE_SECONDO != 2'b00)) begin
         emis_cnt++;
         check("emis_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0)
            check("emis_moves", {CORE_PRIMO, CORE_SECONDO}, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_match(input logic [3:0] cfg);
      CONFIG = cfg;
      AVVIA  = 1'b1;
      @(negedge clk);
      check("init_inizia", CORE_INIZIA, 1);
      check("init_config", {CORE_PRIMO, CORE_SECONDO}, cfg);
      AVVIA = 1'b0;
      @(negedge clk);
      check("raccolta_ready", {P1_READY, P2_READY}, 2'b11);
   endtask

   // Both players present a move together; returns at the negedge inside EMISSIONE.
   task automatic send_both(input logic [1:0] m1, input logic [1:0] m2);
      int n = 0;
      exp_q.push_back({m1, m2});
      P1_MOSSA = m1; P1_VALID = 1'b1;
      P2_MOSSA = m2; P2_VALID = 1'b1;
      while (!(P1_READY && P2_READY) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("send_both_ready_wait", 32'(n < 20), 32'd1);
      @(negedge clk);
      P1_VALID = 1'b0; P2_VALID = 1'b0;
      P1_MOSSA = 2'b00; P2_MOSSA = 2'b00;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int e0, f0, n;
      RST = 1'b1; AVVIA = 1'b0; CONFIG = 4'd0;
      P1_MOSSA = 2'b00; P1_VALID = 1'b0; P2_MOSSA = 2'b00; P2_VALID = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_occupato", OCCUPATO, 0);
      check("rst_ready", {P1_READY, P2_READY}, 0);
      check("rst_core_moves", {CORE_PRIMO, CORE_SECONDO}, 0);
      check("rst_fine", FINE, 0);
      check("rst_esito", ESITO, 0);
      check("rst_forfait", FORFAIT, 0);
      check("rst_n_manche", N_MANCHE, 0);
      check("rst_inizia", CORE_INIZIA, 1);
      RST = 1'b0;
      @(negedge clk);
      check("idle_inizia", CORE_INIZIA, 0);
      check("idle_state", dbg_state, 0);

      // Full match, CONFIG=0 -> 4 rounds, P1 wins every round.
      f0 = fine_cnt;
      start_match(4'd0);
      send_both(2'b01, 2'b11);
      send_both(2'b10, 2'b01);
      send_both(2'b11, 2'b10);
      send_both(2'b01, 2'b11);
      n = 0;
      while (!FINE && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("m1_fine_latency", n, 2);
      check("m1_esito", ESITO, 2'b01);
      check("m1_n_manche", N_MANCHE, 4);
      check("m1_forfait", FORFAIT, 0);
      check("m1_occupato_fine", OCCUPATO, 1);
      @(negedge clk);
      check("m1_fine_pulse", FINE, 0);
      check("m1_idle", OCCUPATO, 0);
      check("m1_esito_held", ESITO, 2'b01);
      check("m1_last_manche", dbg_manche, 2'b01);
      check("m1_fine_count", fine_cnt - f0, 1);

      // P1 holds VALID, P2 arrives 3 cycles later.
      start_match(4'd5);
      check("m2_esito_cleared", ESITO, 0);
      e0 = emis_cnt;
      exp_q.push_back(4'b10_01);
      P1_MOSSA = 2'b10; P1_VALID = 1'b1;
      @(negedge clk);
      check("m2_p1_ready_drop", P1_READY, 0);
      check("m2_p2_ready_high", P2_READY, 1);
      @(negedge clk);
      @(negedge clk);
      check("m2_waiting", dbg_state, 2);
      P2_MOSSA = 2'b01; P2_VALID = 1'b1;
      @(negedge clk);
      check("m2_emissione", dbg_state, 3);
      P1_VALID = 1'b0; P2_VALID = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("m2_one_emission", emis_cnt - e0, 1);
      check("m2_n_manche", N_MANCHE, 1);
      check("m2_back_raccolta", {P1_READY, P2_READY}, 2'b11);

      // Invalid 00 move is consumed and discarded.
      e0 = emis_cnt;
      P1_MOSSA = 2'b00; P1_VALID = 1'b1;
      @(negedge clk);
      check("m3_00_still_ready", P1_READY, 1);
      check("m3_00_state", dbg_state, 2);
      P1_MOSSA = 2'b11;
      @(negedge clk);
      check("m3_11_captured", P1_READY, 0);
      P1_VALID = 1'b0;
      exp_q.push_back(4'b11_10);
      P2_MOSSA = 2'b10; P2_VALID = 1'b1;
      @(negedge clk);
      check("m3_emissione", dbg_state, 3);
      P2_VALID = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("m3_one_emission", emis_cnt - e0, 1);
      check("m3_n_manche", N_MANCHE, 2);

      // AVVIA ignored mid-match, then reset mid-match with P1's register full.
      AVVIA = 1'b1;
      P1_MOSSA = 2'b01; P1_VALID = 1'b1;
      @(negedge clk);
      AVVIA = 1'b0; P1_VALID = 1'b0;
      check("m4_avvia_inizia", CORE_INIZIA, 0);
      check("m4_avvia_state", dbg_state, 2);
      check("m4_p1_held", P1_READY, 0);
      RST = 1'b1;
      #1;
      check("m4_rst_inizia_comb", CORE_INIZIA, 1);
      @(negedge clk);
      check("m4_rst_occupato", OCCUPATO, 0);
      check("m4_rst_esito", ESITO, 0);
      check("m4_rst_n_manche", N_MANCHE, 0);
      check("m4_rst_ready", {P1_READY, P2_READY}, 0);
      check("m4_rst_inizia", CORE_INIZIA, 1);
      RST = 1'b0;
      @(negedge clk);
      check("m4_after_rst_inizia", CORE_INIZIA, 0);
      check("m4_after_rst_state", dbg_state, 0);

      // Only P2 moves; P1 silent.
      f0 = fine_cnt;
      start_match(4'd0);
      P2_MOSSA = 2'b11; P2_VALID = 1'b1;
      @(negedge clk);
      P2_VALID = 1'b0;
      check("m5_p2_captured", P2_READY, 0);
      n = 0;
      while (!FINE && n < 100) begin
         @(negedge clk);
         n++;
      end
`ifdef MORRA_TIMEOUT_EN
      check("m5_timeout_latency", n, 16);
      check("m5_esito", ESITO, 2'b10);
      check("m5_forfait", FORFAIT, 1);
      check("m5_n_manche", N_MANCHE, 0);
      @(negedge clk);
      check("m5_idle", OCCUPATO, 0);
      check("m5_forfait_held", FORFAIT, 1);
`else
      check("m5_no_fine", FINE, 0);
      check("m5_fine_count", fine_cnt - f0, 0);
      check("m5_still_busy", OCCUPATO, 1);
      check("m5_forfait", FORFAIT, 0);
      check("m5_state", dbg_state, 2);
`endif

      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
